// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
//
// Shares one UartTx transmitter among N_REQ byte-stream requesters. The
// transmitter is granted per message with round-robin priority. A grant ends
// when a byte flagged req_last has gone out, when MAX_BURST bytes have been
// sent, or when the owner stops presenting data. Each byte is sequenced
// through the UartTx latch_data/busy handshake.
//
// Ports
//   clk        in   system clock
//   reset      in   asynchronous active-high reset
//   req_valid  in   [N_REQ]   lane i presents a byte
//   req_data   in   [8*N_REQ] lane i byte at [8i+7:8i]
//   req_last   in   [N_REQ]   lane i byte ends a message
//   req_ready  out  [N_REQ]   one-cycle accept pulse for the owner lane
//   tx_data    out  [8]       byte to UartTx.data, held until the next latch
//   tx_latch   out  1         one-cycle pulse to UartTx.latch_data
//   tx_busy    in   1         UartTx.busy
//   grant      out  [N_REQ]   one-hot current owner, 0 when idle
//
// All outputs are registered.
module uart_tx_arbiter #(
    parameter int N_REQ     = 4,
    parameter int MAX_BURST = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [N_REQ-1:0]   req_valid,
    input  logic [8*N_REQ-1:0] req_data,
    input  logic [N_REQ-1:0]   req_last,
    output logic [N_REQ-1:0]   req_ready,
    output logic [7:0]         tx_data,
    output logic               tx_latch,
    input  logic               tx_busy,
    output logic [N_REQ-1:0]   grant
);

    localparam int IDX_W = $clog2(N_REQ);
    localparam int CNT_W = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0] BURST_END = CNT_W'(MAX_BURST);
    // WAIT_START gives up after its third cycle (the latch cycle counts as
    // the first), so a latch that UartTx never saw cannot hang the arbiter.
    localparam logic [1:0] START_TIMEOUT = 2'd2;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        LOAD       = 2'd1,
        WAIT_START = 2'd2,
        WAIT_DONE  = 2'd3
    } state_t;

    function automatic logic [N_REQ-1:0] onehot(input logic [IDX_W-1:0] idx);
        logic [N_REQ-1:0] v;
        v = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (idx == IDX_W'(i)) begin
                v[i] = 1'b1;
            end
        end
        return v;
    endfunction

    state_t             state, state_nxt;
    logic [IDX_W-1:0]   owner, owner_nxt;
    logic [IDX_W-1:0]   last_owner, last_owner_nxt;
    logic [CNT_W-1:0]   byte_cnt, byte_cnt_nxt;
    logic               last_seen, last_seen_nxt;
    logic [1:0]         wait_cnt, wait_cnt_nxt;
    logic [N_REQ-1:0]   grant_nxt;
    logic [N_REQ-1:0]   req_ready_nxt;
    logic [7:0]         tx_data_nxt;
    logic               tx_latch_nxt;

    // Rotating-priority pick: first valid lane after last_owner, with wrap.
    logic               pick_found;
    logic [IDX_W-1:0]   pick_idx;
    int                 cand;

    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        cand       = 0;
        for (int k = 1; k <= N_REQ; k++) begin
            cand = (int'(last_owner) + k) % N_REQ;
            if (!pick_found && req_valid[IDX_W'(cand)]) begin
                pick_found = 1'b1;
                pick_idx   = IDX_W'(cand);
            end
        end
    end

    // Owner lane selection.
    logic               own_valid;
    logic               own_last;
    logic [7:0]         own_byte;

    always_comb begin
        own_valid = 1'b0;
        own_last  = 1'b0;
        own_byte  = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (owner == IDX_W'(i)) begin
                own_valid = req_valid[i];
                own_last  = req_last[i];
                own_byte  = req_data[8*i +: 8];
            end
        end
    end

    logic burst_done;
    assign burst_done = last_seen || (byte_cnt == BURST_END);

    // State and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            owner      <= '0;
            last_owner <= IDX_W'(N_REQ - 1);
            byte_cnt   <= '0;
            last_seen  <= 1'b0;
            wait_cnt   <= '0;
            grant      <= '0;
            req_ready  <= '0;
            tx_data    <= '0;
            tx_latch   <= 1'b0;
        end else begin
            state      <= state_nxt;
            owner      <= owner_nxt;
            last_owner <= last_owner_nxt;
            byte_cnt   <= byte_cnt_nxt;
            last_seen  <= last_seen_nxt;
            wait_cnt   <= wait_cnt_nxt;
            grant      <= grant_nxt;
            req_ready  <= req_ready_nxt;
            tx_data    <= tx_data_nxt;
            tx_latch   <= tx_latch_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (pick_found) begin
                    state_nxt = LOAD;
                end
            end
            LOAD: begin
                if (!own_valid) begin
                    state_nxt = IDLE;
                end else if (!tx_busy) begin
                    state_nxt = WAIT_START;
                end
            end
            WAIT_START: begin
                if (tx_busy || (wait_cnt == START_TIMEOUT)) begin
                    state_nxt = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (!tx_busy) begin
                    state_nxt = burst_done ? IDLE : LOAD;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Next values of the registered outputs and bookkeeping registers.
    always_comb begin
        owner_nxt      = owner;
        last_owner_nxt = last_owner;
        byte_cnt_nxt   = byte_cnt;
        last_seen_nxt  = last_seen;
        wait_cnt_nxt   = wait_cnt;
        grant_nxt      = grant;
        tx_data_nxt    = tx_data;
        tx_latch_nxt   = 1'b0;
        req_ready_nxt  = '0;
        case (state)
            IDLE: begin
                if (pick_found) begin
                    owner_nxt     = pick_idx;
                    grant_nxt     = onehot(pick_idx);
                    byte_cnt_nxt  = '0;
                    last_seen_nxt = 1'b0;
                end
            end
            LOAD: begin
                if (!own_valid) begin
                    grant_nxt      = '0;
                    last_owner_nxt = owner;
                end else if (!tx_busy) begin
                    tx_data_nxt    = own_byte;
                    tx_latch_nxt   = 1'b1;
                    req_ready_nxt  = onehot(owner);
                    byte_cnt_nxt   = byte_cnt + CNT_W'(1);
                    last_seen_nxt  = own_last;
                    wait_cnt_nxt   = '0;
                end
            end
            WAIT_START: begin
                if (!tx_busy && (wait_cnt != START_TIMEOUT)) begin
                    wait_cnt_nxt = wait_cnt + 2'd1;
                end
            end
            WAIT_DONE: begin
                if (!tx_busy && burst_done) begin
                    grant_nxt      = '0;
                    last_owner_nxt = owner;
                end
            end
            default: begin
                grant_nxt = '0;
            end
        endcase
    end

endmodule
